set_assoc_cache_ctrl: RTL and testbench

N-way set-associative, write-back, write-allocate data cache controller. Successor to the direct-mapped controller: parametrised in ways, sets and data width, with dirty-line eviction and a victim policy. Sits between the load/store unit and the DRAM model. One word per line, word-addressed.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/set_assoc_cache_ctrl_if.sv | 36 +++
 rtl/cache_way_array.sv | 42 ++++
 rtl/set_assoc_cache_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// Module      : cache_pkg
// Description : Shared types and width helpers for set_assoc_cache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_COMPARE   = 2'd1,
    S_WRITEBACK = 2'd2,
    S_REFILL    = 2'd3
  } cache_state_t;

  function automatic int index_w(input int count);
    return $clog2(count);
  endfunction

  function automatic int tag_w(input int count);
    return 32 - $clog2(count);
  endfunction

  localparam int C_DEF_INDEX_COUNT = 64;
  localparam int C_DEF_DATA_W      = 32;
  localparam int C_DEF_TAG_W       = tag_w(C_DEF_INDEX_COUNT);

  // Line layout at the default geometry; the controller re-declares it at its own widths.
  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [C_DEF_TAG_W-1:0]  tag;
    logic [C_DEF_DATA_W-1:0] data;
  } cache_line_t;

endpackage

`default_nettype wire

// File: rtl/set_assoc_cache_ctrl_if.sv
// ============================================================================
// Module      : set_assoc_cache_ctrl_if
// Description : CPU request/response and DRAM handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface set_assoc_cache_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_we;
  logic [31:0]           req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  stall;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mem_req;
  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    output stall, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ready, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/cache_way_array.sv
// ============================================================================
// Module      : cache_way_array
// Description : One way of line storage; synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_way_array
  import cache_pkg::*;
#(
  parameter int  INDEX_COUNT = 64,
  parameter type line_t      = cache_line_t,
  localparam int IDX_W       = index_w(INDEX_COUNT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output line_t            rd_line_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  line_t            wr_line_i
);

  line_t mem_q [INDEX_COUNT];

  // Only the status bits are reset; tag/data contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < INDEX_COUNT; i++) begin
        mem_q[i].valid <= 1'b0;
        mem_q[i].dirty <= 1'b0;
      end
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_line_i;
    end
  end

  assign rd_line_o = mem_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/set_assoc_cache_ctrl.sv
// ============================================================================
// Module      : set_assoc_cache_ctrl
// Description : N-way write-back/write-allocate cache controller, round-robin
//               victim. CACHE_PERF_CNT_EN adds hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module set_assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int INDEX_COUNT = 64,
  parameter int WAYS        = 2,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  set_assoc_cache_ctrl_if.slave  bus
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [31:0]            hit_count,
  output logic [31:0]            miss_count
`endif
);

  localparam int INDEX_W   = index_w(INDEX_COUNT);
  localparam int TAG_WIDTH = tag_w(INDEX_COUNT);
  localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic                  valid;
    logic                  dirty;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } line_t;

  cache_state_t          state_q, state_d;
  logic [31:0]           addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [WAY_W-1:0]      victim_q;
  logic [WAY_W-1:0]      rr_q [INDEX_COUNT];

  logic [INDEX_W-1:0]    w_idx;
  logic [TAG_WIDTH-1:0]  w_tag;
  line_t                 w_lines [WAYS];
  logic                  w_hit;
  logic [WAY_W-1:0]      w_hit_way;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_wr_en;
  logic [WAY_W-1:0]      w_wr_way;
  line_t                 w_wr_line;
  logic                  w_rr_adv;
  logic                  w_rsp_valid;
  logic [DATA_WIDTH-1:0] w_rsp_rdata;
  logic                  w_mem_req;
  logic                  w_mem_we;
  logic [31:0]           w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_wdata;

  assign w_idx = addr_q[INDEX_W-1:0];
  assign w_tag = addr_q[31:INDEX_W];

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_array #(
      .INDEX_COUNT (INDEX_COUNT),
      .line_t      (line_t)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .rd_idx_i  (w_idx),
      .rd_line_o (w_lines[g]),
      .we_i      (w_wr_en && (w_wr_way == WAY_W'(g))),
      .wr_idx_i  (w_idx),
      .wr_line_i (w_wr_line)
    );
  end

  // Descending scans so the lowest-numbered matching way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_victim  = rr_q[w_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_lines[w].valid && (w_lines[w].tag == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
      if (!w_lines[w].valid) begin
        w_victim = WAY_W'(w);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    w_rsp_valid = 1'b0;
    w_rsp_rdata = '0;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    w_wr_en     = 1'b0;
    w_wr_way    = victim_q;
    w_wr_line   = '0;
    w_rr_adv    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) state_d = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          w_rsp_valid = 1'b1;
          state_d     = S_IDLE;
          if (we_q) begin
            w_wr_en        = 1'b1;
            w_wr_way       = w_hit_way;
            w_wr_line      = w_lines[w_hit_way];
            w_wr_line.dirty = 1'b1;
            w_wr_line.data = wdata_q;
          end else begin
            w_rsp_rdata = w_lines[w_hit_way].data;
          end
        end else if (w_lines[w_victim].valid && w_lines[w_victim].dirty) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {w_lines[victim_q].tag, w_idx};
        w_mem_wdata = w_lines[victim_q].data;
        if (bus.mem_ready) begin
          w_wr_en         = 1'b1;
          w_wr_line       = w_lines[victim_q];
          w_wr_line.dirty = 1'b0;
          state_d         = S_REFILL;
        end
      end
      S_REFILL: begin
        w_mem_req  = 1'b1;
        w_mem_addr = addr_q;
        if (bus.mem_ready) begin
          w_wr_en         = 1'b1;
          w_wr_line.valid = 1'b1;
          w_wr_line.dirty = 1'b0;
          w_wr_line.tag   = w_tag;
          w_wr_line.data  = bus.mem_rdata;
          w_rr_adv        = 1'b1;
          state_d         = S_COMPARE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      victim_q <= '0;
      for (int i = 0; i < INDEX_COUNT; i++) rr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && bus.req_valid) begin
        addr_q  <= bus.req_addr;
        we_q    <= bus.req_we;
        wdata_q <= bus.req_wdata;
      end
      if (state_q == S_COMPARE) victim_q <= w_victim;
      if (w_rr_adv) begin
        rr_q[w_idx] <= (rr_q[w_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[w_idx] + 1'b1;
      end
    end
  end

  assign bus.stall     = (state_q != S_IDLE);
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_rdata;
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

`ifdef CACHE_PERF_CNT_EN
  logic        replay_q;
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // The COMPARE right after a refill is the replay, not a fresh outcome.
  always_ff @(posedge clk) begin
    if (rst) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q <= (state_q == S_REFILL) && bus.mem_ready;
      if (state_q == S_COMPARE && w_hit && !replay_q && hit_cnt_q != '1) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (state_q == S_COMPARE && !w_hit && miss_cnt_q != '1) begin
        miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_set_assoc_cache_ctrl.sv
// ============================================================================
// Module      : tb_set_assoc_cache_ctrl
// Description : Randomized self-checking bench with a behavioural cache model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_set_assoc_cache_ctrl;

  localparam int L    = 3;
  localparam int WAYS = 2;
  localparam int SETS = 64;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  set_assoc_cache_ctrl_if #(.DATA_WIDTH(32)) bus ();

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  set_assoc_cache_ctrl #(
    .INDEX_COUNT (SETS),
    .WAYS        (WAYS),
    .DATA_WIDTH  (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents seen by DRAM (environment) and by the reference model.
  logic [31:0] dram    [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  txn_t        log_q   [$];

  bit          m_valid [SETS][WAYS];
  bit          m_dirty [SETS][WAYS];
  logic [25:0] m_tag   [SETS][WAYS];
  logic [31:0] m_data  [SETS][WAYS];
  int          m_rr    [SETS];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] dram_read(input logic [31:0] a);
    if (dram.exists(a)) return dram[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    logic [31:0] r;
    r = 32'hX;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[int'(a[5:0])][w] && m_tag[int'(a[5:0])][w] == a[31:6]) r = m_data[int'(a[5:0])][w];
    return r;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
  endtask

  // DRAM: mem_ready in the L-th cycle of a request; tolerates dropped requests.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst || !bus.mem_req) begin
        cnt = 0;
        bus.mem_ready = 1'b0;
      end else begin
        if (bus.mem_ready) cnt = 0;
        cnt++;
        bus.mem_ready = (cnt == L);
        if (bus.mem_ready) begin
          if (bus.mem_we) begin
            dram[bus.mem_addr] = bus.mem_wdata;
            log_q.push_back(txn_t'{1'b1, bus.mem_addr, bus.mem_wdata});
          end else begin
            bus.mem_rdata = dram_read(bus.mem_addr);
            log_q.push_back(txn_t'{1'b0, bus.mem_addr, bus.mem_rdata});
          end
        end
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int          s, hw, v, lat, cyc;
    bit          got, idle;
    logic [25:0] tg;
    logic [31:0] exp_rd, rd, wa, obs_rd;
    txn_t        exp_q [$];
    s  = int'(addr[5:0]);
    tg = addr[31:6];
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) hw = w;
    if (hw >= 0) begin
      lat = 1;
      if (we) begin
        m_data[s][hw]  = wdata;
        m_dirty[s][hw] = 1'b1;
        exp_rd = '0;
      end else begin
        exp_rd = m_data[s][hw];
      end
    end else begin
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) v = m_rr[s];
      lat = 2 + L;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        wa = {m_tag[s][v], addr[5:0]};
        exp_q.push_back(txn_t'{1'b1, wa, m_data[s][v]});
        ref_mem[wa] = m_data[s][v];
        lat += L;
      end
      rd = ref_read(addr);
      exp_q.push_back(txn_t'{1'b0, addr, rd});
      m_valid[s][v] = 1'b1;
      m_dirty[s][v] = we;
      m_tag[s][v]   = tg;
      m_data[s][v]  = we ? wdata : rd;
      m_rr[s]       = (m_rr[s] + 1) % WAYS;
      exp_rd        = we ? 32'h0 : rd;
    end

    idle = 1'b0;
    for (int i = 0; i < 100 && !idle; i++) begin
      @(negedge clk);
      idle = !bus.stall;
    end
    n_checks++;
    if (!idle) $display("FAIL idle_wait addr=%h: stall still %b, required 0", addr, bus.stall);
    else n_pass++;

    log_q.delete();
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    cyc = 0;
    got = 1'b0;
    obs_rd = '0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      got = bus.rsp_valid;
      obs_rd = bus.rsp_rdata;
    end

    n_checks++;
    if (!got || cyc != lat) $display("FAIL latency addr=%h: got %0d cycles (rsp=%b), required %0d", addr, cyc, got, lat);
    else n_pass++;
    n_checks++;
    if (obs_rd !== exp_rd) $display("FAIL rdata addr=%h: got %h, required %h", addr, obs_rd, exp_rd);
    else n_pass++;
    n_checks++;
    if (log_q.size() != exp_q.size()) $display("FAIL mem_txn_count addr=%h: got %0d, required %0d", addr, log_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      n_checks++;
      if (log_q[i] !== exp_q[i])
        $display("FAIL mem_txn[%0d] addr=%h: got we=%b a=%h d=%h, required we=%b a=%h d=%h", i, addr,
                 log_q[i].we, log_q[i].addr, log_q[i].data, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.stall !== 1'b0)     $display("FAIL rst_stall: got %b, required 0", bus.stall);         else n_pass++;
    n_checks++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b, required 0", bus.rsp_valid); else n_pass++;
    n_checks++; if (bus.rsp_rdata !== '0)   $display("FAIL rst_rsp_rdata: got %h, required 0", bus.rsp_rdata); else n_pass++;
    n_checks++; if (bus.mem_req !== 1'b0)   $display("FAIL rst_mem_req: got %b, required 0", bus.mem_req);     else n_pass++;
    n_checks++; if (bus.mem_we !== 1'b0)    $display("FAIL rst_mem_we: got %b, required 0", bus.mem_we);       else n_pass++;
    n_checks++; if (bus.mem_addr !== '0)    $display("FAIL rst_mem_addr: got %h, required 0", bus.mem_addr);   else n_pass++;
    n_checks++; if (bus.mem_wdata !== '0)   $display("FAIL rst_mem_wdata: got %h, required 0", bus.mem_wdata); else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_miss_then_hit();
    do_access(1'b0, 32'h0000_0005, 32'h0);
    do_access(1'b0, 32'h0000_0005, 32'h0);
  endtask

  task automatic test_dirty_evict();
    apply_reset();
    do_access(1'b1, 32'h45, 32'hDEAD_BEEF);
    do_access(1'b1, 32'h85, 32'h0BAD_F00D);
    do_access(1'b0, 32'hC5, 32'h0);
    n_checks++;
    if (log_q.size() < 1 || log_q[0] !== txn_t'{1'b1, 32'h45, 32'hDEAD_BEEF})
      $display("FAIL evict_wb: got %0d txns, first a=%h, required writeback a=00000045 d=deadbeef",
               log_q.size(), (log_q.size() > 0) ? log_q[0].addr : 32'h0);
    else n_pass++;
    n_checks++;
    if (log_q.size() < 2 || log_q[1].addr !== 32'hC5 || log_q[1].we !== 1'b0)
      $display("FAIL evict_refill: got %0d txns, required refill of 000000c5 second", log_q.size());
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_access(1'b0, 32'h09, 32'h0);
    do_access(1'b0, 32'h49, 32'h0);
    do_access(1'b0, 32'h89, 32'h0);
    do_access(1'b0, 32'hC9, 32'h0);
    do_access(1'b0, 32'h89, 32'h0);
    do_access(1'b0, 32'h09, 32'h0);
  endtask

  task automatic test_random();
    int          sets [4] = '{3, 5, 9, 17};
    logic [31:0] a;
    for (int n = 0; n < 80; n++) begin
      a = {26'($urandom_range(0, 3)), 6'(sets[$urandom_range(0, 3)])};
      do_access(1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea, eb;
    do_access(1'b0, 32'h1A, 32'h0);
    do_access(1'b0, 32'h5A, 32'h0);
    ea = model_word(32'h1A);
    eb = model_word(32'h5A);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h1A;
    @(posedge clk);
    #1 bus.req_addr = 32'h5A;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== ea)
      $display("FAIL b2b_first: got rsp=%b data=%h, required rsp=1 data=%h", bus.rsp_valid, bus.rsp_rdata, ea);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL b2b_gap: got rsp=%b stall=%b, required 0/0", bus.rsp_valid, bus.stall);
    else n_pass++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== eb)
      $display("FAIL b2b_second: got rsp=%b data=%h, required rsp=1 data=%h", bus.rsp_valid, bus.rsp_rdata, eb);
    else n_pass++;
  endtask

  task automatic test_reset_mid_refill();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h3F0;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h3F0)
      $display("FAIL refill_req: got req=%b we=%b a=%h, required 1/0/000003f0", bus.mem_req, bus.mem_we, bus.mem_addr);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.stall !== 1'b0)
      $display("FAIL rst_mid_refill: got mem_req=%b stall=%b, required 0/0", bus.mem_req, bus.stall);
    else n_pass++;
    rst = 1'b0;
    model_reset();
    do_access(1'b0, 32'h5, 32'h0);
    do_access(1'b0, 32'h3F0, 32'h0);
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf();
    apply_reset();
    n_checks++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0)
      $display("FAIL perf_reset: got hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
    else n_pass++;
    repeat (3) do_access(1'b0, 32'h5, 32'h0);
    n_checks++;
    if (hit_count !== 32'd2 || miss_count !== 32'd1)
      $display("FAIL perf_counts: got hit=%0d miss=%0d, required 2/1", hit_count, miss_count);
    else n_pass++;
  endtask
`endif

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    test_reset();
    test_miss_then_hit();
    test_dirty_evict();
    test_round_robin();
    test_random();
    test_back_to_back();
    test_reset_mid_refill();
`ifdef CACHE_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
